// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier.
// State encodings and the default operand width.
package mult_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/add_stage.sv
// Combinational WIDTH-bit ripple-carry adder.
// Built from one full adder per bit.
module add_stage #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i] = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i])
                      | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one add and one
// right shift per cycle, valid/ready on both sides.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    assign addend = acc[0] ? mcand : '0;

    add_stage #(.WIDTH(WIDTH)) u_add (
        .sum  (sum),
        .cout (cout),
        .x    (acc[2*WIDTH-1:WIDTH]),
        .y    (addend),
        .cin  (1'b0)
    );

    // Carry becomes the new MSB, so the shift never loses a bit.
    assign acc_next = {cout, sum, acc[WIDTH-1:1]};
    assign last     = (count == CW'(WIDTH - 1));

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            mcand   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (last) begin
                        product <= acc_next;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random checks of shift_add_mult
// against a product scoreboard.
module tb_shift_add_mult;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2*WIDTH-1:0] sb[$];

    shift_add_mult #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 1);
    endtask

    task automatic accept(input logic [WIDTH-1:0] ai,
                          input logic [WIDTH-1:0] bi);
        in_valid = 1'b1;
        a = ai;
        b = bi;
        tick();
        sb.push_back((2*WIDTH)'(ai) * (2*WIDTH)'(bi));
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] ai,
                         input logic [WIDTH-1:0] bi,
                         input int hold,
                         input bit glitch);
        int n;
        logic [2*WIDTH-1:0] exp_p;
        wait_idle();
        out_ready = (hold == 0);
        accept(ai, bi);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (glitch && n < 3) begin
                in_valid = 1'b1;
                a = 8'h11;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), WIDTH);
        exp_p = (sb.size() > 0) ? sb.pop_front() : 'x;
        check("product", 32'(product), 32'(exp_p));
        check("in_ready_done", 32'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_ready", 32'(in_ready), 0);
            check("bp_product", 32'(product), 32'(exp_p));
        end
        out_ready = 1'b1;
        tick();
        check("hs_valid", 32'(out_valid), 0);
        check("hs_ready", 32'(in_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_product", 32'(product), 0);
        check("rst_no_x",
              32'($isunknown({in_ready, out_valid, product})), 0);
        rst_n = 1'b1;
        tick();

        do_op(8'hD9, 8'h6D, 0, 1'b0);
        check("d9x6d", 32'(product), 32'h5C65);
        do_op(8'hFF, 8'hFF, 0, 1'b0);
        check("ffxff", 32'(product), 32'hFE01);
        do_op(8'h00, 8'h5A, 0, 1'b0);
        check("00x5a", 32'(product), 32'h0000);
        do_op(8'h01, 8'h80, 0, 1'b0);
        check("01x80", 32'(product), 32'h0080);

        do_op(8'hA5, 8'h3C, 5, 1'b0);

        wait_idle();
        accept(8'h77, 8'h99);
        repeat (3) tick();
        check("pre_rst_busy", 32'(in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(sb.pop_back());
        check("mid_rst_ready", 32'(in_ready), 1);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_product", 32'(product), 0);
        do_op(8'h03, 8'h04, 0, 1'b0);
        check("3x4", 32'(product), 32'h000C);

        do_op(8'h5B, 8'hC2, 0, 1'b1);
        check("glitch", 32'(product), 32'h44F6);

        for (int k = 0; k < 1000; k++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom),
                  int'($urandom_range(0, 2)), 1'b0);
        end
        check("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
